// File: rtl/alu_reg_file_if.sv
// ---------------------------------------------------------------------------
// alu_reg_file_if
//   Bus between the ALU datapath and its register file.
//   Parameters:
//     WIDTH : data width of operands and write-back data
//     AW    : register address width
//   Signals:
//     we, waddr, wdata       : write-back port (ALU result s)
//     re, raddr_a, raddr_b   : read request and operand addresses
//     a, b, rvalid           : registered operands and their valid flag
//   Modports:
//     master : datapath side, drives requests and consumes operands
//     slave  : register file side
// ---------------------------------------------------------------------------
interface alu_reg_file_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             rvalid;

    modport master (
        output we, waddr, wdata, re, raddr_a, raddr_b,
        input  a, b, rvalid
    );

    modport slave (
        input  we, waddr, wdata, re, raddr_a, raddr_b,
        output a, b, rvalid
    );
endinterface

// File: rtl/alu_reg_file.sv
// ---------------------------------------------------------------------------
// alu_reg_file
//   DEPTH x WIDTH register file feeding the ALU operands a/b and capturing
//   the ALU result. One synchronous write port, two registered read ports
//   with one-cycle latency and write-to-read bypass on the same edge.
//   Ports:
//     clk : clock, all state changes on rising edge
//     rst : asynchronous active-high reset, clears storage and outputs
//     bus : alu_reg_file_if.slave (write port, read request, operands)
// ---------------------------------------------------------------------------
module alu_reg_file #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic            clk,
    input  logic            rst,
    alu_reg_file_if.slave   bus
);

    logic [WIDTH-1:0] r [DEPTH];
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             rvalid_q;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;

    // Operand selection: a write landing on the same edge wins over storage,
    // so a dependent instruction issued right behind its producer sees the
    // fresh result.
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        a_next = r[bus.raddr_a];
        b_next = r[bus.raddr_b];
        if (bus.we && (bus.waddr == bus.raddr_a)) begin
            a_next = bus.wdata;
        end
        if (bus.we && (bus.waddr == bus.raddr_b)) begin
            b_next = bus.wdata;
        end
    end

    // Storage. Every register must read back zero after reset, so the array
    // is cleared here rather than left to power-up contents.
    // NOTE: this array is reset, which rules out a RAM macro; acceptable here
    // because the file is tiny and reset-to-zero contents are part of its
    // contract.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r[i] <= '0;
            end
        end else if (bus.we) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r[bus.waddr] <= bus.wdata;
        end
    end

    // Read port registers: operands hold while re is low, rvalid pulses
    // for exactly the cycle after each accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= bus.re;
            if (bus.re) begin
                a_q <= a_next;
                b_q <= b_next;
            end
        end
    end

    assign bus.a      = a_q;
    assign bus.b      = b_q;
    assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_alu_reg_file.sv
// ---------------------------------------------------------------------------
// tb_alu_reg_file
//   Self-checking bench for alu_reg_file. A behavioural model (plain array
//   of register contents plus expected operand values) is advanced once per
//   clock and compared with the DUT after every edge.
// ---------------------------------------------------------------------------
module tb_alu_reg_file;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk;
    logic rst;

    alu_reg_file_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    alu_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [WIDTH-1:0] mdl [DEPTH];
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
    logic             exp_v;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".a"}, bus.a, exp_a);
        check({tag, ".b"}, bus.b, exp_b);
        check({tag, ".rvalid"}, {15'd0, bus.rvalid}, {15'd0, exp_v});
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        exp_a = '0;
        exp_b = '0;
        exp_v = 1'b0;
    endtask

    // Advance one clock: model consumes the inputs presented before the
    // edge, then the bench moves to 1 time unit after the edge.
    task automatic cycle();
        if (bus.re) begin
            exp_a = (bus.we && bus.waddr == bus.raddr_a) ? bus.wdata : mdl[bus.raddr_a];
            exp_b = (bus.we && bus.waddr == bus.raddr_b) ? bus.wdata : mdl[bus.raddr_b];
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        if (bus.we) mdl[bus.waddr] = bus.wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] waddr,
                         input logic [WIDTH-1:0] wdata, input logic re,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        bus.we      = we;
        bus.waddr   = waddr;
        bus.wdata   = wdata;
        bus.re      = re;
        bus.raddr_a = ra;
        bus.raddr_b = rb;
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs are
    // checked before any further edge arrives.
    task automatic mid_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    logic [WIDTH-1:0] held_a;
    logic [WIDTH-1:0] held_b;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        model_reset();
        #1;
        check_all("reset_initial");
        // Inputs toggle while reset is held: nothing may change.
        drive(1'b1, 3'd2, 16'hDEAD, 1'b1, 3'd2, 3'd2);
        @(posedge clk);
        #1;
        check_all("reset_ignores_inputs");
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;

        // Reset check: preload r[3], read it, then pulse reset mid-cycle.
        drive(1'b1, 3'd3, 16'hBEEF, 1'b0, '0, '0);
        cycle();
        drive(1'b0, '0, '0, 1'b1, 3'd3, 3'd3);
        cycle();
        check_all("preload_r3");
        mid_reset("async_reset");
        drive(1'b0, '0, '0, 1'b1, 3'd3, 3'd3);
        cycle();
        check_all("r3_after_reset");
        check("r3_after_reset.const", bus.a, 16'h0000);

        // Write then read.
        drive(1'b1, 3'd1, 16'h00FF, 1'b0, '0, '0);
        cycle();
        drive(1'b1, 3'd2, 16'hFF00, 1'b0, '0, '0);
        cycle();
        drive(1'b0, '0, '0, 1'b1, 3'd1, 3'd2);
        cycle();
        check_all("write_read");
        check("write_read.a_const", bus.a, 16'h00FF);
        check("write_read.b_const", bus.b, 16'hFF00);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        cycle();
        check_all("write_read.valid_drops");

        // Bypass on the same edge.
        drive(1'b1, 3'd5, 16'hAAAA, 1'b0, '0, '0);
        cycle();
        drive(1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 3'd5);
        cycle();
        check_all("bypass");
        check("bypass.a_const", bus.a, 16'h1234);
        check("bypass.b_const", bus.b, 16'h1234);
        drive(1'b0, '0, '0, 1'b1, 3'd5, 3'd0);
        cycle();
        check_all("bypass.from_storage");

        // Invert round-trip through the ALU.
        drive(1'b1, 3'd4, 16'h0F0F, 1'b0, '0, '0);
        cycle();
        drive(1'b0, '0, '0, 1'b1, 3'd4, 3'd4);
        cycle();
        check_all("invert.read");
        drive(1'b1, 3'd4, ~bus.a, 1'b0, '0, '0);
        cycle();
        drive(1'b0, '0, '0, 1'b1, 3'd4, 3'd1);
        cycle();
        check_all("invert.readback");
        check("invert.const", bus.a, 16'hF0F0);

        // Hold and valid.
        drive(1'b1, 3'd6, 16'h6666, 1'b0, '0, '0);
        cycle();
        drive(1'b0, '0, '0, 1'b1, 3'd6, 3'd6);
        cycle();
        check_all("hold.read");
        held_a = exp_a;
        held_b = exp_b;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'd6, 16'h5555, 1'b0, 3'd6, 3'd6);
            cycle();
            check_all("hold.idle");
            check("hold.a_const", bus.a, held_a);
            check("hold.b_const", bus.b, held_b);
        end

        // Streaming after a fresh reset.
        mid_reset("stream_reset");
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, AW'(i), 16'(i) * 16'h1111, 1'b1, AW'(i), AW'((i + DEPTH - 1) % DEPTH));
            cycle();
            check_all("stream");
            sa = 16'(i) * 16'h1111;
            sb = (i == 0) ? 16'h0000 : 16'(i - 1) * 16'h1111;
            check("stream.a_formula", bus.a, sa);
            check("stream.b_formula", bus.b, sb);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom), WIDTH'($urandom),
                  1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom));
            cycle();
            check_all("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_reg_file.md
# alu_reg_file

Register file that sits on both ends of the ALU datapath. It supplies the 16-bit `a` and `b` operands to the ALU units (invert, add, logic) and captures the 16-bit result `s` written back from them. It has one synchronous write port and two registered read ports. Reads have a one-cycle latency, are qualified by a valid flag, and bypass a same-cycle write so back-to-back dependent ALU operations see fresh data.

## Interface
- `WIDTH`, 16, data width of every register and port
- `DEPTH`, 8, number of registers
- `AW`, 3, address width; `DEPTH` must equal 2**`AW`
- `clk`  input  1  single clock, all state updates on rising edge
- `rst`  input  1  reset, asynchronous and active-high; clears all state immediately
- `we`  input  1  write enable, sampled at rising `clk`
- `waddr`  input  AW  write address
- `wdata`  input  WIDTH  write data (ALU result `s`)
- `re`  input  1  read request, sampled at rising `clk`
- `raddr_a`  input  AW  read address for operand a
- `raddr_b`  input  AW  read address for operand b
- `a`  output  WIDTH  registered operand a to ALU
- `b`  output  WIDTH  registered operand b to ALU
- `rvalid`  output  1  high for exactly the cycle after each accepted `re`

## Operation
- Storage: `DEPTH` x `WIDTH` registers `r[0..DEPTH-1]`. All registers are writable; there is no hardwired zero.
- Write: on rising `clk` with `we`=1, `r[waddr]` <= `wdata`. With `we`=0, storage is unchanged.
- Read: on rising `clk` with `re`=1:
  - `a` <= (`we` && `waddr`==`raddr_a`) ? `wdata` : `r[raddr_a]`.
  - `b` is driven the same way from `raddr_b`.
  - `rvalid` <= 1.
- Idle: with `re`=0, `a` and `b` hold their previous values and `rvalid` <= 0.
- Same address on both read ports: `a` and `b` get identical values, including bypassed data.
- Bypass applies only to the same-edge write. Data written in earlier cycles is read from storage normally.
- The write and read paths are independent. `we` and `re` may both be high every cycle and there is no backpressure.
- Writes apply no arithmetic or width change; `wdata` is stored bit-exact.

## Timing
- Reset (`rst`=1, asynchronous, no clock needed):
  - all `r[i]` = 16'h0000
  - `a` = 16'h0000, `b` = 16'h0000, `rvalid` = 0
- While `rst` is high, `we` and `re` are ignored.
- Reset deasserted: the first rising `clk` with `rst`=0 is the first edge that may write or read.
- Read latency: 1 cycle. If `re` is sampled at edge N, `a`, `b` and `rvalid`=1 are valid after edge N and until edge N+1.
- Write visibility: 0 cycles via bypass at edge N; from storage at edge N+1 onward.
- Reset mid-operation: a `rst` pulse between edges clears the outputs and storage immediately. A read pending from the previous edge loses its data and `rvalid` falls at once.
- Out-of-range addresses cannot occur, since `DEPTH` = 2**`AW`.

## Test plan
- Reset check:
  - Stimulus: preload `r[3]`=16'hBEEF, then pulse `rst` between clock edges.
  - Response: `a`, `b` and `rvalid` are 0 immediately, without waiting for a clock edge.
  - Follow-up: a later read of `r[3]` returns 16'h0000.
- Write then read:
  - Stimulus: write 16'h00FF to `r[1]` and 16'hFF00 to `r[2]`; next cycle `re`=1, `raddr_a`=1, `raddr_b`=2.
  - Response: `a`=16'h00FF, `b`=16'hFF00, `rvalid`=1 for exactly one cycle.
- Bypass:
  - Stimulus: same edge `we`=1, `waddr`=5, `wdata`=16'h1234; `re`=1, `raddr_a`=5, `raddr_b`=5; `r[5]` previously 16'hAAAA.
  - Response: `a`=`b`=16'h1234.
- Invert round-trip:
  - Stimulus: store 16'h0F0F in `r[4]`, read it to `a`, write the ALU invert result back to `r[4]`, then read again.
  - Response: the value read back is 16'hF0F0.
- Hold and valid:
  - Stimulus: `re`=1 for one cycle, then 0 for three cycles while writing 16'h5555 to the address that was read.
  - Response: `a` and `b` hold their old values, and `rvalid` is high for only the first cycle.
- Streaming:
  - Stimulus: `we` and `re` high every cycle for 8 cycles; `waddr`=i, `wdata`=i*16'h1111; `raddr_a`=i, `raddr_b`=(i-1) mod 8, with all registers cleared by `rst` beforehand.
  - Response for operand a: `a`=i*16'h1111 each cycle via bypass.
  - Response for operand b: `b`=(i-1)*16'h1111 for i≥1; `b`=16'h0000 for i=0, since `r[7]` still holds its reset value.
